// File: rtl/aq_udp_echo.sv
// aq_udp_echo: UDP echo client for the GEMAC user side.
// Drains one received datagram into a local word buffer, then re-sends it
// unchanged through the send-UDP port with fixed source/destination ports.
// Oversized or empty datagrams are read out and discarded.
module aq_udp_echo #(
    parameter int          BUF_AW       = 9,
    parameter logic [15:0] ECHO_SRCPORT = 16'd1234,
    parameter logic [15:0] ECHO_DSTPORT = 16'd1234
) (
    input  logic        RST_N,
    input  logic        CLK100M,
    input  logic        ENABLE,
    input  logic        REC_REQUEST,
    input  logic [15:0] REC_LENGTH,
    input  logic        REC_BUSY,
    input  logic        REC_DATA_VALID,
    output logic        REC_DATA_READ,
    input  logic [31:0] REC_DATA,
    output logic        SEND_REQUEST,
    output logic [15:0] SEND_LENGTH,
    input  logic        SEND_BUSY,
    output logic [15:0] SEND_DSTPORT,
    output logic [15:0] SEND_SRCPORT,
    output logic        SEND_DATA_VALID,
    input  logic        SEND_DATA_READ,
    output logic [31:0] SEND_DATA,
    output logic [15:0] ECHO_COUNT,
    output logic [15:0] DROP_COUNT
);

    typedef enum logic [2:0] {
        S_IDLE, S_RECV, S_DROP, S_REQ, S_SEND, S_DONE
    } state_t;

    localparam logic [16:0] BUF_WORDS = 17'(2 ** BUF_AW);

    state_t            state, nxt;
    logic [16:0]       nw_in;      // word count of the pending datagram
    logic [16:0]       nw_q;       // latched word count
    logic [16:0]       cnt;        // transfers done in the current phase
    logic [15:0]       len_q;
    logic [BUF_AW-1:0] wr_ptr, rd_ptr;
    logic [31:0]       mem [2**BUF_AW];
    logic              rec_fire, send_fire, last, accept;
    logic              unused_rec_busy;

    // Controller receive-busy carries no information this block needs.
    assign unused_rec_busy = REC_BUSY;

    assign nw_in     = ({1'b0, REC_LENGTH} + 17'd3) >> 2;
    assign rec_fire  = REC_DATA_VALID & REC_DATA_READ;
    assign send_fire = SEND_DATA_VALID & SEND_DATA_READ;
    assign last      = (cnt == nw_q - 17'd1);
    assign accept    = (state == S_IDLE) & REC_REQUEST & ENABLE;

    assign SEND_SRCPORT = ECHO_SRCPORT;
    assign SEND_DSTPORT = ECHO_DSTPORT;
    assign SEND_LENGTH  = len_q;

    // State register
    always_ff @(posedge CLK100M or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= nxt;
    end

    // Next-state logic
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: if (REC_REQUEST && ENABLE)
                        nxt = (nw_in == 17'd0 || nw_in > BUF_WORDS) ? S_DROP : S_RECV;
            S_RECV: if (rec_fire && last) nxt = S_REQ;
            S_DROP: if (nw_q == 17'd0 || (rec_fire && last)) nxt = S_IDLE;
            S_REQ:  if (SEND_BUSY) nxt = S_SEND;
            S_SEND: if (send_fire && last) nxt = S_DONE;
            S_DONE: if (!SEND_BUSY) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state; an empty drop reads nothing
    always_comb begin
        REC_DATA_READ = (state == S_RECV) || (state == S_DROP && nw_q != 17'd0);
        SEND_REQUEST  = (state == S_REQ);
    end

    // Buffer write port; contents are don't-care across reset
    always_ff @(posedge CLK100M) begin
        if (state == S_RECV && rec_fire) mem[wr_ptr] <= REC_DATA;
    end

    // Datapath: length latch, pointers, show-ahead send register, counters
    always_ff @(posedge CLK100M or negedge RST_N) begin
        if (!RST_N) begin
            len_q           <= '0;
            nw_q            <= '0;
            cnt             <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            SEND_DATA_VALID <= 1'b0;
            SEND_DATA       <= '0;
            ECHO_COUNT      <= '0;
            DROP_COUNT      <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    len_q <= REC_LENGTH;
                    nw_q  <= nw_in;
                    cnt   <= '0;
                end
                S_RECV: if (rec_fire) begin
                    wr_ptr <= wr_ptr + 1'b1;   // wraps to 0 on a full buffer
                    cnt    <= cnt + 17'd1;
                end
                S_DROP: begin
                    if (rec_fire) cnt <= cnt + 17'd1;
                    if ((nw_q == 17'd0 || (rec_fire && last)) && DROP_COUNT != 16'hFFFF)
                        DROP_COUNT <= DROP_COUNT + 16'd1;
                end
                S_REQ: if (SEND_BUSY) begin
                    // preload word 0 so it is valid on the first SEND cycle
                    SEND_DATA       <= mem[0];
                    SEND_DATA_VALID <= 1'b1;
                    rd_ptr          <= BUF_AW'(1);
                    cnt             <= '0;
                end
                S_SEND: if (send_fire) begin
                    cnt <= cnt + 17'd1;
                    if (last) begin
                        SEND_DATA_VALID <= 1'b0;
                    end else begin
                        SEND_DATA <= mem[rd_ptr];
                        rd_ptr    <= rd_ptr + 1'b1;
                    end
                end
                S_DONE: if (!SEND_BUSY) begin
                    if (ECHO_COUNT != 16'hFFFF) ECHO_COUNT <= ECHO_COUNT + 16'd1;
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
